// File: rtl/st_video_pkg.sv
// Shared types and constants for the st_video grayscale stage.
package st_video_pkg;

  localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;
  localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;

  // BT.601-style luma weights scaled by 256; they sum to exactly 256
  localparam logic [15:0] LUMA_COEF_R = 16'd77;
  localparam logic [15:0] LUMA_COEF_G = 16'd150;
  localparam logic [15:0] LUMA_COEF_B = 16'd29;
  localparam logic [15:0] LUMA_ROUND  = 16'd128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CTRL  = 2'd1,
    VIDEO = 2'd2
  } pkt_state_e;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [23:0] data;
  } beat_t;

endpackage

// File: rtl/st_video_gray_luma.sv
// S2 stage: registered RGB-to-luma multiply-add with valid/sop/eop passthrough.
module rgb_to_luma
  import st_video_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic        in_conv,
  input  logic [23:0] in_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic [23:0] out_data
);

  logic [15:0] acc;
  logic [7:0]  y;

  // Weighted sum fits in 16 bits (max 256*255+128), so no saturation.
  always_comb begin
    acc = LUMA_COEF_R * {8'd0, in_data[7:0]}
        + LUMA_COEF_G * {8'd0, in_data[15:8]}
        + LUMA_COEF_B * {8'd0, in_data[23:16]}
        + LUMA_ROUND;
    y   = 8'(acc >> 8);
  end

  // Register the converted (or untouched) beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      out_sop   <= in_sop;
      out_eop   <= in_eop;
      out_data  <= in_conv ? {y, y, y} : in_data;
    end
  end

endmodule

// File: rtl/st_video_gray.sv
// Avalon-ST video grayscale stage: packet FSM, two-stage pipeline, output FIFO.
//
// state | meaning
// IDLE  | between packets; non-sop beats are dropped
// CTRL  | inside a control packet; beats forwarded unchanged
// VIDEO | inside a video packet; beats after the header are pixels
module st_video_gray
  import st_video_pkg::*;
#(
  parameter int VIDEO_W    = 1920,
  parameter int VIDEO_H    = 1080,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] asi_data,
  input  logic        asi_valid,
  input  logic        asi_sop,
  input  logic        asi_eop,
  output logic        asi_ready,
  output logic [23:0] aso_data,
  output logic        aso_valid,
  output logic        aso_sop,
  output logic        aso_eop,
  input  logic        aso_ready,
  input  logic        gray_en,
  output logic [31:0] frame_cnt,
  output logic        err_short,
  output logic        err_long,
  input  logic        err_clr
);

  localparam int FRAME_PIX = VIDEO_W * VIDEO_H;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = $clog2(FRAME_PIX + 2);
  localparam logic [CW-1:0] PIX_FULL  = CW'(FRAME_PIX);
  localparam logic [CW-1:0] PIX_OVER  = CW'(FRAME_PIX + 1);
  localparam logic [AW+1:0] OCC_LIMIT = (AW+2)'(FIFO_DEPTH - 3);

  pkt_state_e    state, state_nxt;
  logic [CW-1:0] pix_cnt, pix_nxt, pix_inc;
  logic          gray_q, gray_nxt;
  logic          fwd, is_pix, set_short, set_long, frame_inc;
  logic          run_q;

  logic          s1_valid, s1_sop, s1_eop, s1_conv;
  logic [23:0]   s1_data;
  logic          s2_valid, s2_sop, s2_eop;
  logic [23:0]   s2_data;

  beat_t         mem [FIFO_DEPTH];
  beat_t         head;
  logic [AW:0]   wr_ptr, rd_ptr, fifo_used;
  logic          fifo_empty, pre_ready;
  logic [AW+1:0] occ;

  // Pixel count saturates one past a full frame so over-long packets never wrap.
  always_comb begin
    pix_inc = (pix_cnt == PIX_OVER) ? pix_cnt : pix_cnt + 1'b1;
  end

  // Next-state and beat classification; only accepted beats advance the FSM.
  always_comb begin
    state_nxt = state;
    pix_nxt   = pix_cnt;
    gray_nxt  = gray_q;
    fwd       = 1'b0;
    is_pix    = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    frame_inc = 1'b0;
    if (asi_valid) begin
      if (asi_sop) begin
        // A sop always restarts; an open video packet is closed as short if incomplete.
        fwd     = 1'b1;
        pix_nxt = '0;
        if (state == VIDEO && pix_cnt < PIX_FULL) set_short = 1'b1;
        if (asi_data[3:0] == PKT_TYPE_VIDEO) begin
          gray_nxt = gray_en;
          if (asi_eop) begin
            set_short = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = VIDEO;
          end
        end else begin
          state_nxt = asi_eop ? IDLE : CTRL;
        end
      end else begin
        case (state)
          IDLE: ;
          CTRL: begin
            fwd = 1'b1;
            if (asi_eop) state_nxt = IDLE;
          end
          VIDEO: begin
            fwd     = 1'b1;
            is_pix  = 1'b1;
            pix_nxt = pix_inc;
            if (pix_cnt == PIX_FULL) set_long = 1'b1;
            if (asi_eop) begin
              state_nxt = IDLE;
              if (pix_inc == PIX_FULL) frame_inc = 1'b1;
              else if (pix_inc < PIX_FULL) set_short = 1'b1;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // FSM state, pixel count and the gray_en value latched at video sop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pix_cnt <= '0;
      gray_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pix_cnt <= pix_nxt;
      gray_q  <= gray_nxt;
    end
  end

  // S1: register the forwarded beat and whether it needs conversion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_conv  <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= fwd;
      s1_sop   <= asi_sop;
      s1_eop   <= asi_eop;
      s1_conv  <= is_pix & gray_q;
      s1_data  <= asi_data;
    end
  end

  rgb_to_luma u_luma (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_valid),
    .in_sop    (s1_sop),
    .in_eop    (s1_eop),
    .in_conv   (s1_conv),
    .in_data   (s1_data),
    .out_valid (s2_valid),
    .out_sop   (s2_sop),
    .out_eop   (s2_eop),
    .out_data  (s2_data)
  );

  // FIFO storage; contents are only observed when the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (s2_valid) mem[wr_ptr[AW-1:0]] <= {s2_sop, s2_eop, s2_data};
  end

  // FIFO pointers carry an extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (s2_valid)  wr_ptr <= wr_ptr + 1'b1;
      if (aso_valid) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Source side honours ready latency 1 by delaying aso_ready one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre_ready <= 1'b0;
    else       pre_ready <= aso_ready;
  end

  // Holds asi_ready low until the first clock after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) run_q <= 1'b0;
    else       run_q <= 1'b1;
  end

  // Backpressure leaves room for the beat already in flight on the sink plus pipeline.
  always_comb begin
    fifo_used  = wr_ptr - rd_ptr;
    fifo_empty = (fifo_used == '0);
    occ        = {1'b0, fifo_used} + (AW+2)'(s1_valid) + (AW+2)'(s2_valid);
    asi_ready  = run_q & (occ <= OCC_LIMIT);
    head       = mem[rd_ptr[AW-1:0]];
    aso_valid  = pre_ready & ~fifo_empty;
    aso_data   = fifo_empty ? '0   : head.data;
    aso_sop    = fifo_empty ? 1'b0 : head.sop;
    aso_eop    = fifo_empty ? 1'b0 : head.eop;
  end

  // Frame counter and sticky size errors; a set event beats err_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      if (frame_inc) frame_cnt <= frame_cnt + 32'd1;
      if (set_short)    err_short <= 1'b1;
      else if (err_clr) err_short <= 1'b0;
      if (set_long)     err_long  <= 1'b1;
      else if (err_clr) err_long  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_st_video_gray.sv
// Randomized bench for st_video_gray with a packet-level reference model.
module tb_st_video_gray;
  import st_video_pkg::*;

  localparam int W = 4, H = 2, WH = W * H, DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] asi_data = '0;
  logic        asi_valid = 1'b0, asi_sop = 1'b0, asi_eop = 1'b0;
  logic        asi_ready;
  logic [23:0] aso_data;
  logic        aso_valid, aso_sop, aso_eop;
  logic        aso_ready = 1'b0;
  logic        gray_en = 1'b0;
  logic [31:0] frame_cnt;
  logic        err_short, err_long;
  logic        err_clr = 1'b0;

  st_video_gray #(.VIDEO_W(W), .VIDEO_H(H), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .asi_data(asi_data), .asi_valid(asi_valid), .asi_sop(asi_sop), .asi_eop(asi_eop),
    .asi_ready(asi_ready),
    .aso_data(aso_data), .aso_valid(aso_valid), .aso_sop(aso_sop), .aso_eop(aso_eop),
    .aso_ready(aso_ready),
    .gray_en(gray_en), .frame_cnt(frame_cnt), .err_short(err_short), .err_long(err_long),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic        sop;
    logic        eop;
    logic        gray;
  } beat_s;

  beat_s       beat_q[$];
  logic [25:0] exp_q[$];
  logic [25:0] log_q[$];
  int total = 0, bad = 0;
  int sink_duty = 80, src_duty = 100;

  // reference model state: kind 0=no packet, 1=control, 2=video
  int          m_kind = 0;
  int          m_npix = 0;
  bit          m_g = 0;
  logic [31:0] m_frames = '0;
  bit          m_short = 0, m_long = 0;

  function automatic logic [23:0] model_pix(logic [23:0] d, bit g);
    int y;
    logic [7:0] y8;
    y  = (77 * int'(d[7:0]) + 150 * int'(d[15:8]) + 29 * int'(d[23:16]) + 128) / 256;
    y8 = 8'(y);
    return g ? {y8, y8, y8} : d;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  task automatic push_beat(logic [23:0] d, bit s, bit e, bit g);
    beat_s b;
    b.data = d; b.sop = s; b.eop = e; b.gray = g;
    beat_q.push_back(b);
  endtask

  task automatic push_video(int n, bit g, bit close);
    push_beat({20'($urandom), PKT_TYPE_VIDEO}, 1'b1, close && (n == 0), g);
    for (int i = 0; i < n; i++)
      push_beat(24'($urandom), 1'b0, close && (i == n - 1), 1'($urandom_range(0, 1)));
  endtask

  task automatic push_ctrl(logic [23:0] first, int n);
    push_beat(first, 1'b1, n == 1, 1'b0);
    for (int i = 1; i < n; i++) push_beat(24'($urandom), 1'b0, i == n - 1, 1'b0);
  endtask

  // sink driver: valid only after a cycle in which asi_ready was high
  initial begin : driver
    bit    ready_d;
    beat_s b;
    ready_d = 0;
    forever begin
      @(negedge clk);
      if (reset || !ready_d || beat_q.size() == 0 || $urandom_range(0, 99) >= sink_duty) begin
        asi_valid = 1'b0;
      end else begin
        b = beat_q.pop_front();
        asi_valid = 1'b1;
        asi_data  = b.data;
        asi_sop   = b.sop;
        asi_eop   = b.eop;
        gray_en   = b.gray;
      end
      ready_d = asi_ready;
    end
  end

  initial begin : src_ready
    forever begin
      @(negedge clk);
      aso_ready = ($urandom_range(0, 99) < src_duty);
    end
  end

  // reference model: consumes each accepted beat at the clock edge
  always @(posedge clk) begin : model
    bit ss, sl;
    ss = 0; sl = 0;
    if (reset) begin
      m_kind = 0; m_npix = 0; m_g = 0; m_frames = '0; m_short = 0; m_long = 0;
      exp_q.delete();
    end else begin
      if (asi_valid) begin
        if (asi_sop) begin
          if (m_kind == 2 && m_npix < WH) ss = 1;
          m_npix = 0;
          m_kind = (asi_data[3:0] == PKT_TYPE_VIDEO) ? 2 : 1;
          if (m_kind == 2) m_g = gray_en;
          exp_q.push_back({1'b1, asi_eop, asi_data});
          if (asi_eop) begin
            if (m_kind == 2) ss = 1;
            m_kind = 0;
          end
        end else if (m_kind == 1) begin
          exp_q.push_back({1'b0, asi_eop, asi_data});
          if (asi_eop) m_kind = 0;
        end else if (m_kind == 2) begin
          m_npix++;
          if (m_npix == WH + 1) sl = 1;
          exp_q.push_back({1'b0, asi_eop, model_pix(asi_data, m_g)});
          if (asi_eop) begin
            if (m_npix == WH) m_frames = m_frames + 1;
            else if (m_npix < WH) ss = 1;
            m_kind = 0;
          end
        end
      end
      if (ss) m_short = 1; else if (err_clr) m_short = 0;
      if (sl) m_long = 1;  else if (err_clr) m_long = 0;
    end
  end

  // compare process: every cycle, away from the active edge
  initial begin : compare
    logic [25:0] act;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        chk("rst_aso_valid", aso_valid, 0);
        chk("rst_aso_beat", {aso_sop, aso_eop, aso_data}, 0);
        chk("rst_asi_ready", asi_ready, 0);
        chk("rst_status", {frame_cnt, err_short, err_long}, 0);
      end else begin
        chk("fifo_bound", dut.fifo_used <= DEPTH, 1);
        chk("frame_cnt", frame_cnt, m_frames);
        chk("err_short", err_short, m_short);
        chk("err_long", err_long, m_long);
        if (aso_valid) begin
          act = {aso_sop, aso_eop, aso_data};
          log_q.push_back(act);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL out_beat: got %0h want no beat", act);
          end else begin
            chk("out_beat", act, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic drain(bit rnd_clr);
    int n;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      err_clr = rnd_clr && ($urandom_range(0, 9) == 0);
      #2;
      if (beat_q.size() == 0 && !asi_valid && exp_q.size() == 0) break;
      n++;
    end
    err_clr = 1'b0;
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size() + beat_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #800000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : main
    logic [23:0] px[8];
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // model pinned to hand-computed luma values
    chk("pin_red",   model_pix(24'h0000FF, 1), 24'h4D4D4D);
    chk("pin_white", model_pix(24'hFFFFFF, 1), 24'hFFFFFF);
    chk("pin_green", model_pix(24'h00FF00, 1), 24'h959595);
    chk("pin_pass",  model_pix(24'h123456, 0), 24'h123456);

    // control packet then a gray video frame
    push_ctrl({20'h0, PKT_TYPE_CTRL}, 4);
    push_beat(24'h000000, 1, 0, 1);
    push_beat(24'h0000FF, 0, 0, 0);
    for (int i = 0; i < 7; i++) push_beat(24'($urandom), 0, i == 6, 0);
    drain(0);
    chk("t1_len", log_q.size(), 13);
    chk("t1_ctrl0", log_q[0], {2'b10, 24'h00000F});
    chk("t1_vsop", log_q[4], {2'b10, 24'h000000});
    chk("t1_red", log_q[5], {2'b00, 24'h4D4D4D});
    chk("t1_frames", frame_cnt, 1);
    log_q.delete();

    // gray conversion of white/green, then pass-through frame
    push_beat(24'h000000, 1, 0, 1);
    push_beat(24'hFFFFFF, 0, 0, 0);
    push_beat(24'h00FF00, 0, 0, 0);
    for (int i = 0; i < 6; i++) push_beat(24'($urandom), 0, i == 5, 0);
    drain(0);
    chk("t2_white", log_q[1], {2'b00, 24'hFFFFFF});
    chk("t2_green", log_q[2], {2'b00, 24'h959595});
    log_q.delete();
    push_beat(24'h000000, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      px[i] = 24'($urandom);
      push_beat(px[i], 0, i == 7, 1);
    end
    drain(0);
    for (int i = 0; i < 8; i++) chk("t2_pass", log_q[i + 1], {1'b0, i == 7, px[i]});
    chk("t2_frames", frame_cnt, 3);

    // frame size checks
    push_video(8, 1, 1);
    drain(0);
    chk("t3_exact_frames", frame_cnt, 4);
    chk("t3_exact_short", err_short, 0);
    push_video(6, 1, 1);
    drain(0);
    chk("t3_short", err_short, 1);
    chk("t3_short_frames", frame_cnt, 4);
    pulse_clr();
    chk("t3_clr", err_short, 0);
    log_q.delete();
    push_video(10, 0, 1);
    drain(0);
    chk("t3_long", err_long, 1);
    chk("t3_long_len", log_q.size(), 11);
    chk("t3_long_frames", frame_cnt, 4);
    chk("t3_long_short", err_short, 0);
    pulse_clr();
    chk("t3_long_clr", err_long, 0);

    // stray beats in IDLE and restart mid video
    log_q.delete();
    push_beat(24'($urandom), 0, 0, 0);
    push_beat(24'($urandom), 0, 1, 0);
    push_beat(24'($urandom), 0, 0, 1);
    push_video(3, 1, 0);
    push_video(8, 1, 1);
    drain(0);
    chk("t5_len", log_q.size(), 13);
    chk("t5_restart_sop", log_q[4][25], 1);
    chk("t5_short", err_short, 1);
    chk("t5_frames", frame_cnt, 5);
    pulse_clr();

    // random traffic under heavy source backpressure
    src_duty = 30;
    sink_duty = 100;
    for (int p = 0; p < 50; p++) begin
      int k;
      k = $urandom_range(0, 99);
      if (k < 20)      push_ctrl({20'($urandom), 4'($urandom_range(1, 15))}, $urandom_range(1, 5));
      else if (k < 30) push_beat(24'($urandom), 0, 1'($urandom_range(0, 1)), 0);
      else if (k < 40) push_video($urandom_range(1, 5), 1'($urandom_range(0, 1)), 0);
      else if (k < 45) push_video(0, 1'($urandom_range(0, 1)), 1);
      else             push_video($urandom_range(WH - 2, WH + 3), 1'($urandom_range(0, 1)), 1);
    end
    push_video(WH, 1, 1);
    drain(1);
    src_duty = 100;
    sink_duty = 80;

    // reset in the middle of a frame
    push_video(8, 1, 1);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    asi_valid = 1'b0;
    beat_q.delete();
    @(negedge clk);
    #1;
    chk("t6_valid", aso_valid, 0);
    chk("t6_frames", frame_cnt, 0);
    chk("t6_ready", asi_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    log_q.delete();
    push_beat(24'($urandom), 0, 0, 0);
    push_beat(24'($urandom), 0, 1, 0);
    push_ctrl(24'h12345F, 2);
    push_video(8, 0, 1);
    drain(0);
    chk("t6_first_sop", log_q[0], {2'b10, 24'h12345F});
    chk("t6_len", log_q.size(), 11);
    chk("t6_frames_after", frame_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
